// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: 8N1 UART transmitter fed by an internal byte FIFO, LSB first, idle-high line.
// Latency: byte pushed into an empty FIFO at edge N is popped at N+1; tx falls after edge N+2.
// Backpressure: none on the push side; pushes while full are dropped and set the sticky overflow flag.
//
// Ports:
//   clk_t       transmit clock (rising edge)        rst        async active-high reset
//   wr_en       push wr_data this cycle             wr_data    byte to send
//   fifo_full   FIFO holds FIFO_DEPTH bytes         fifo_empty FIFO holds no bytes
//   fifo_count  bytes queued (not counting shifter) overflow   sticky: push attempted while full
//   tx          serial line                         tx_busy    serializer in START/DATA/STOP
//   dma_txend   FIFO empty and serializer idle
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk_t,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              tx,
  output logic              tx_busy,
  output logic              dma_txend
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        tsr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        idx;
  state_t            state;

  state_t            state_nxt;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [2:0]        idx_nxt;
  logic              pop;
  logic              push;
  logic              tx_nxt;
  logic [ADDR_W:0]   count_nxt;

  // A full FIFO refuses the byte even if the serializer pops in the same cycle.
  assign push      = wr_en && !fifo_full;
  assign count_nxt = fifo_count + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);

  // Next-state and next-line-level. The line level is computed from the
  // current state and registered, so tx trails the state by one cycle and
  // every bit, including the idle cycle between frames, keeps its full width.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    idx_nxt     = idx;
    pop         = 1'b0;
    tx_nxt      = 1'b1;
    case (state)
      TX_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop         = 1'b1;
          state_nxt   = TX_START;
          bit_cnt_nxt = '0;
        end
      end
      TX_START: begin
        tx_nxt = 1'b0;
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          idx_nxt     = 3'd0;
          state_nxt   = TX_DATA;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        tx_nxt = tsr[idx];
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          if (idx == 3'd7) begin
            state_nxt = TX_STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        tx_nxt = 1'b1;
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          state_nxt   = TX_IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = TX_IDLE;
      end
    endcase
  end

  // FIFO storage is deliberately left out of reset.
  always_ff @(posedge clk_t) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_t or posedge rst) begin
    if (rst) begin
      state      <= TX_IDLE;
      bit_cnt    <= '0;
      idx        <= 3'd0;
      tsr        <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      dma_txend  <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      idx     <= idx_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (wr_en && fifo_full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        tsr    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      fifo_count <= count_nxt;
      fifo_full  <= (count_nxt == DEPTH_V);
      fifo_empty <= (count_nxt == '0);
      tx         <= tx_nxt;
      tx_busy    <= (state != TX_IDLE);
      dma_txend  <= !tx_busy && fifo_empty && (state == TX_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: scoreboard bench for uart_fifo_tx (fast instance plus a full-rate loopback instance).
// Stimulus pushes the bytes it expects on the wire into queues; line decoders pop and compare.
// All inputs change just after the falling clock edge; all outputs are sampled there.
module tb_uart_fifo_tx;

  localparam int CPB = 4;

  logic       clk_t = 1'b0;
  logic       rst   = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_full, fifo_empty, overflow, tx, tx_busy, dma_txend;
  logic [2:0] fifo_count;

  logic       wr_en2 = 1'b0;
  logic [7:0] wr_data2 = 8'h00;
  logic       fifo_full2, fifo_empty2, overflow2, tx2, tx_busy2, dma_txend2;
  logic [4:0] fifo_count2;

  always #5 clk_t = ~clk_t;

  uart_fifo_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
    .clk_t(clk_t), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .overflow(overflow), .tx(tx), .tx_busy(tx_busy), .dma_txend(dma_txend)
  );

  uart_fifo_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(16), .ADDR_W(4)) dut2 (
    .clk_t(clk_t), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2),
    .fifo_full(fifo_full2), .fifo_empty(fifo_empty2), .fifo_count(fifo_count2),
    .overflow(overflow2), .tx(tx2), .tx_busy(tx_busy2), .dma_txend(dma_txend2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int frames_seen = 0;
  int rx2_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  int start_q[$];

  always @(posedge clk_t) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_t);
  endtask

  task automatic wait_idle(input int max_cyc, input string nm);
    int n = 0;
    while (dma_txend !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check(nm, {31'd0, dma_txend}, 32'd1);
  endtask

  // Line decoder for the fast instance: samples every cycle of a frame so bit
  // widths are checked exactly, then compares against the scoreboard queue.
  initial begin : monitor
    logic [39:0] samp;
    logic [7:0]  got;
    logic [7:0]  e;
    logic        aborted;
    int          unstable;
    int          st;
    forever begin
      @(negedge clk_t);
      if (!rst && tx === 1'b0) begin
        samp    = '0;
        aborted = 1'b0;
        st      = cyc;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk_t);
          samp[i] = tx;
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          frames_seen++;
          start_q.push_back(st);
          unstable = 0;
          for (int b = 0; b < 10; b++)
            for (int s = 1; s < CPB; s++)
              if (samp[b*CPB+s] !== samp[b*CPB]) unstable++;
          for (int b = 0; b < 8; b++) got[b] = samp[CPB + CPB*b];
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h, expected no frame", got);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'd0, got}, {24'd0, e});
            check("stop_bit", {31'd0, samp[36]}, 32'd1);
            check("bit_width_stable", unstable, 0);
          end
        end
      end
    end
  end

  // Mid-bit sampling receiver for the full-rate instance.
  initial begin : receiver2
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(negedge clk_t);
      if (!rst && tx2 === 1'b0) begin
        repeat (433) @(negedge clk_t);
        check("rx_start_bit", {31'd0, tx2}, 32'd0);
        for (int b = 0; b < 8; b++) begin
          repeat (868) @(negedge clk_t);
          d[b] = tx2;
        end
        repeat (868) @(negedge clk_t);
        check("rx_stop_bit", {31'd0, tx2}, 32'd1);
        rx2_cnt++;
        if (exp2_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got %02h, expected no byte", d);
        end else begin
          e = exp2_q.pop_front();
          check("rx_byte", {24'd0, d}, {24'd0, e});
        end
      end
    end
  end

  initial begin : stim
    int t_low, t_high, tx_fall, b_rise, b_fall;
    int frames_before;
    logic [7:0] t2 [3];
    logic [7:0] t3 [5];
    int exp_cnt3 [5];
    int n;

    t2 = '{8'h00, 8'hFF, 8'h3C};
    t3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_cnt3 = '{1, 2, 3, 4, 4};

    // Reset values
    repeat (3) tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_dma_txend", {31'd0, dma_txend}, 32'd1);
    check("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: single byte 0xA5, exact timing relative to the push edge
    t_low = -1; t_high = -1; tx_fall = -1; b_rise = -1; b_fall = -1;
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k > 0) tick();
      if (k == 0) begin
        check("t1_empty_after_push", {31'd0, fifo_empty}, 32'd0);
        check("t1_count_after_push", {29'd0, fifo_count}, 32'd1);
      end
      if (k == 1) check("t1_count_after_pop", {29'd0, fifo_count}, 32'd0);
      if (dma_txend === 1'b0 && t_low < 0) t_low = k;
      if (t_low >= 0 && dma_txend === 1'b1 && t_high < 0) t_high = k;
      if (tx === 1'b0 && tx_fall < 0) tx_fall = k;
      if (tx_busy === 1'b1 && b_rise < 0) b_rise = k;
      if (b_rise >= 0 && tx_busy === 1'b0 && b_fall < 0) b_fall = k;
    end
    check("t1_txend_fall", t_low, 1);
    check("t1_tx_fall", tx_fall, 2);
    check("t1_busy_rise", b_rise, 2);
    check("t1_busy_fall", b_fall, 42);
    check("t1_txend_rise", t_high, 43);

    // 2: three back-to-back bytes, 1 idle cycle between frames
    start_q.delete();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = t2[i]; exp_q.push_back(t2[i]);
      tick();
    end
    wr_en = 1'b0;
    tick();
    wait_idle(300, "t2_idle_timeout");
    tick();
    check("t2_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("t2_gap_1_2", start_q[1] - start_q[0], 41);
      check("t2_gap_2_3", start_q[2] - start_q[1], 41);
    end

    // 3: overfill while busy
    frames_before = frames_seen;
    wr_en = 1'b1; wr_data = 8'hC3; exp_q.push_back(8'hC3);
    tick();
    wr_en = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = t3[i];
      if (i < 4) exp_q.push_back(t3[i]);
      tick();
      check("t3_count", {29'd0, fifo_count}, exp_cnt3[i]);
      check("t3_full", {31'd0, fifo_full}, (i >= 3) ? 32'd1 : 32'd0);
      check("t3_overflow", {31'd0, overflow}, (i == 4) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0;
    tick();
    wait_idle(400, "t3_idle_timeout");
    tick();
    check("t3_frames", frames_seen - frames_before, 5);
    check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

    // 4: push coincident with pop at count 2, pointer wrap
    wr_en = 1'b1; wr_data = 8'hA1; exp_q.push_back(8'hA1);
    tick();                                   // after edge N
    wr_en = 1'b0;
    tick(); tick();                           // after N+2
    wr_en = 1'b1; wr_data = 8'hB2; exp_q.push_back(8'hB2);
    tick();                                   // after N+3
    wr_data = 8'hC3; exp_q.push_back(8'hC3);
    tick();                                   // after N+4
    wr_en = 1'b0;
    repeat (37) tick();                       // after N+41
    check("t4_count_before", {29'd0, fifo_count}, 32'd2);
    wr_en = 1'b1; wr_data = 8'hD4; exp_q.push_back(8'hD4);
    tick();                                   // after N+42: push + pop
    check("t4_count_push_pop", {29'd0, fifo_count}, 32'd2);
    wr_data = 8'hE5; exp_q.push_back(8'hE5);
    tick();
    wr_data = 8'hF6; exp_q.push_back(8'hF6);
    tick();
    wr_en = 1'b0;
    check("t4_count_full", {29'd0, fifo_count}, 32'd4);
    check("t4_full", {31'd0, fifo_full}, 32'd1);
    tick();
    wait_idle(400, "t4_idle_timeout");
    tick();

    // 5: reset during data bit 3 of 0x81
    frames_before = frames_seen;
    wr_en = 1'b1; wr_data = 8'h81;
    tick();
    wr_en = 1'b0;
    repeat (19) tick();
    check("t5_data_bit3", {31'd0, tx}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_tx", {31'd0, tx}, 32'd1);
    check("t5_rst_busy", {31'd0, tx_busy}, 32'd0);
    check("t5_rst_txend", {31'd0, dma_txend}, 32'd1);
    check("t5_rst_empty", {31'd0, fifo_empty}, 32'd1);
    check("t5_rst_full", {31'd0, fifo_full}, 32'd0);
    check("t5_rst_count", {29'd0, fifo_count}, 32'd0);
    check("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (60) tick();
    check("t5_no_frame", frames_seen - frames_before, 0);
    check("t5_tx_idle", {31'd0, tx}, 32'd1);

    // 6: loopback at full bit rate
    wr_en2 = 1'b1; wr_data2 = 8'h55; exp2_q.push_back(8'h55);
    tick();
    wr_data2 = 8'h0F; exp2_q.push_back(8'h0F);
    tick();
    wr_en2 = 1'b0;
    tick();
    n = 0;
    while (dma_txend2 !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    check("t6_idle", {31'd0, dma_txend2}, 32'd1);
    repeat (5) tick();
    check("t6_rx_count", rx2_cnt, 2);

    check("scoreboard_drained", exp_q.size() + exp2_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
